// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: queues bytes stored to TX_ADDR and hands them to the Uart one at a time, paced by uart_busy.
// Optional feature: define UART_TX_SCHED_CRLF_EN to expand every queued LF (8'h0A) into CR,LF.
module uart_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'h1001_0000,
    parameter logic [31:0] CTRL_ADDR    = 32'h1001_0004,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 bus_address,
    input  logic [31:0]                 bus_write_data,
    input  logic                        bus_write_enable,
    input  logic                        uart_busy,
    output logic [7:0]                  uart_data,
    output logic                        uart_write_enable,
    output logic                        fifo_empty,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] push_amt;
    logic             overflow_q, overflow_d;
    logic [7:0]       uart_data_q, uart_data_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic tx_store, ctrl_store, flush, clr_ovf;
    logic push_two, push_fits, push_ok, drop;
    logic fifo_ready, timeout_hit, pop;
    logic unused_wdata;

    assign tx_store   = bus_write_enable && (bus_address == TX_ADDR);
    assign ctrl_store = bus_write_enable && (bus_address == CTRL_ADDR);
    assign flush      = ctrl_store && bus_write_data[1];
    assign clr_ovf    = ctrl_store && bus_write_data[0];
    assign unused_wdata = ^bus_write_data[31:8];

`ifdef UART_TX_SCHED_CRLF_EN
    assign push_two = (bus_write_data[7:0] == 8'h0A);
`else
    assign push_two = 1'b0;
`endif

    // Room is judged on the registered count only; a pop in the same cycle never makes room.
    assign push_fits = push_two ? (count_q <= (DEPTH_C - CNT_W'(2))) : (count_q < DEPTH_C);
    assign push_ok   = tx_store && !flush && push_fits;
    assign drop      = tx_store && !flush && !push_fits;
    assign push_amt  = push_ok ? (push_two ? CNT_W'(2) : CNT_W'(1)) : '0;
    assign wr_ptr_inc = wr_ptr_q + 1'b1;

    // A flush in this cycle suppresses the start of a new issue.
    assign fifo_ready  = (count_q != '0) && !flush;
    assign timeout_hit = (32'(timer_q) + 32'd2) >= 32'(BUSY_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (fifo_ready) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT_HI;
            S_WAIT_HI: if (uart_busy || timeout_hit) state_d = S_WAIT_LO;
            S_WAIT_LO: if (!uart_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // The head byte is popped and latched on the edge entering ISSUE so it is stable under the pulse.
    always_comb begin
        uart_write_enable = (state_q == S_ISSUE);
        pop               = (state_q == S_IDLE) && fifo_ready;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        uart_data_d = uart_data_q;
        timer_d     = '0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_amt);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + push_amt - CNT_W'(pop);
        end
        if (pop) begin
            uart_data_d = mem_q[rd_ptr_q];
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (state_q == S_WAIT_HI) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            uart_data_q <= '0;
            timer_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            uart_data_q <= uart_data_d;
            timer_q     <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            if (push_two) begin
                mem_q[wr_ptr_q]   <= 8'h0D;
                mem_q[wr_ptr_inc] <= 8'h0A;
            end else begin
                mem_q[wr_ptr_q] <= bus_write_data[7:0];
            end
        end
    end

    assign uart_data  = uart_data_q;
    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed steps plus random bursts checked against a byte-queue reference model.
module tb_uart_tx_scheduler;
    localparam int          DEPTH = 16;
    localparam int          BT    = 4;
    localparam logic [31:0] TXA   = 32'h1001_0000;
    localparam logic [31:0] CTLA  = 32'h1001_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic        bus_write_enable = 1'b0;
    logic        uart_busy = 1'b0;
    logic [7:0]  uart_data;
    logic        uart_write_enable;
    logic        fifo_empty, fifo_full, overflow;
    logic [4:0]  fifo_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Uart model: 0 = busy never rises, 1 = busy for busy_len cycles from the cycle after a pulse, 2 = stuck high
    int busy_mode = 0;
    int busy_len = 1;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] b;
        int         cyc;
        logic       busy;
    } pulse_t;
    pulse_t     pulses[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .FIFO_DEPTH(DEPTH), .TX_ADDR(TXA), .CTRL_ADDR(CTLA), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_write_enable(bus_write_enable), .uart_busy(uart_busy),
        .uart_data(uart_data), .uart_write_enable(uart_write_enable),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy_mode == 2) begin
            uart_busy <= 1'b1;
        end else if (busy_mode == 1 && uart_write_enable === 1'b1) begin
            uart_busy <= 1'b1;
            busy_cnt  <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            uart_busy <= 1'b0;
            busy_cnt  <= 0;
        end
    end

    always @(negedge clk) begin
        if (uart_write_enable === 1'b1) pulses.push_back('{uart_data, cyc, uart_busy});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_address      = a;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
        bus_address      = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: what the Uart must eventually receive for one accepted store.
    task automatic model_push(input logic [7:0] b);
`ifdef UART_TX_SCHED_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endtask

    task automatic drain(input string tag, input bit chk_busy);
        int n;
        int waited;
        n = exp_q.size();
        waited = 0;
        while (pulses.size() < n && waited < 2000) begin
            tick();
            waited++;
        end
        repeat (24) tick();
        chk({tag, "_npulses"}, 32'(pulses.size()), 32'(n));
        for (int i = 0; i < n && i < pulses.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(pulses[i].b), 32'(exp_q[i]));
            if (chk_busy) chk($sformatf("%s_busy%0d", tag, i), 32'(pulses[i].busy), 32'd0);
        end
        chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        pulses.delete();
        exp_q.delete();
    endtask

    initial begin
        int mcnt;
        bit movf;
        int waited;
        int k;

        // Reset held two cycles while a TX store is presented
        rst = 1'b0;
        bus_address = TXA; bus_write_data = 32'h55; bus_write_enable = 1'b1;
        tick();
        pulses.delete();
        tick();
        rst = 1'b1; bus_write_enable = 1'b0; bus_address = '0;
        repeat (4) tick();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(uart_data), 32'd0);
        chk("rst_pulses", 32'(pulses.size()), 32'd0);

        // Ordering with a Uart that goes busy the cycle after each pulse
        busy_mode = 1; busy_len = 10;
        for (int i = 0; i < 3; i++) begin
            model_push(8'h41 + 8'(i));
            store(TXA, 32'h41 + 32'(i));
        end
        drain("order", 1'b1);
        chk("order_hold", 32'(uart_data), 32'h43);

        // Fill past full with busy stuck high, then release and drain through the wrap
        busy_mode = 2;
        repeat (2) tick();
        exp_q.push_back(8'h00);
        store(TXA, 32'h0);
        repeat (6) tick();
        chk("full_first_issue", 32'(pulses.size()), 32'd1);
        mcnt = 0; movf = 1'b0;
        for (int b = 1; b < 20; b++) begin
            if (mcnt < DEPTH) begin
                exp_q.push_back(8'(b));
                mcnt++;
            end else begin
                movf = 1'b1;
            end
            store(TXA, 32'(b));
        end
        chk("full_count", 32'(fifo_count), 32'(mcnt));
        chk("full_flag", 32'(fifo_full), 32'(mcnt == DEPTH));
        chk("full_ovf", 32'(overflow), 32'(movf));
        busy_mode = 1; busy_len = 2;
        drain("wrap", 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        store(CTLA, 32'h1);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Busy never rises: pulse spacing is set by the timeout alone
        busy_mode = 0;
        model_push(8'h5A); store(TXA, 32'h5A);
        model_push(8'hA5); store(TXA, 32'hA5);
        waited = 0;
        while (pulses.size() < 2 && waited < 200) begin
            tick();
            waited++;
        end
        chk("tmo_spacing", 32'(pulses[1].cyc - pulses[0].cyc), 32'(BT + 2));
        drain("tmo", 1'b1);

        // Flush after the first byte is in flight
        busy_mode = 1; busy_len = 8;
        for (int i = 0; i < 5; i++) store(TXA, 32'h60 + 32'(i));
        store(CTLA, 32'h2);
        chk("flush_count", 32'(fifo_count), 32'd0);
        repeat (40) tick();
        chk("flush_pulses", 32'(pulses.size()), 32'd1);
        chk("flush_byte", 32'(pulses[0].b), 32'h60);
        chk("flush_empty", 32'(fifo_empty), 32'd1);
        pulses.delete();

        // Same sequence, ended by reset instead of flush
        for (int i = 0; i < 5; i++) store(TXA, 32'h70 + 32'(i));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstmid_count", 32'(fifo_count), 32'd0);
        chk("rstmid_data", 32'(uart_data), 32'd0);
        repeat (40) tick();
        chk("rstmid_pulses", 32'(pulses.size()), 32'd1);
        chk("rstmid_byte", 32'(pulses[0].b), 32'h70);
        pulses.delete();

        // LF handling
        busy_mode = 1; busy_len = 3;
        model_push(8'h0A); store(TXA, 32'h0A);
        drain("lf", 1'b1);
        busy_mode = 2;
        repeat (2) tick();
        exp_q.push_back(8'h30);
        store(TXA, 32'h30);
        repeat (6) tick();
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(8'h40 + 8'(i));
            store(TXA, 32'h40 + 32'(i));
        end
        chk("lf_pre_count", 32'(fifo_count), 32'd15);
        store(TXA, 32'h0A);
`ifdef UART_TX_SCHED_CRLF_EN
        chk("lf_fill_count", 32'(fifo_count), 32'd15);
        chk("lf_fill_ovf", 32'(overflow), 32'd1);
`else
        exp_q.push_back(8'h0A);
        chk("lf_fill_count", 32'(fifo_count), 32'd16);
        chk("lf_fill_ovf", 32'(overflow), 32'd0);
`endif
        busy_mode = 1; busy_len = 2;
        drain("lf_fill", 1'b0);
        store(CTLA, 32'h1);

        // Random bursts, each drained before the next; stores to other addresses must be ignored
        for (int r = 0; r < 25; r++) begin
            busy_mode = int'($urandom_range(0, 1));
            busy_len  = int'($urandom_range(1, 10));
            k = int'($urandom_range(1, 8));
            for (int j = 0; j < k; j++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                model_push(b);
                store(TXA, {24'($urandom), b});
                if ($urandom_range(0, 3) == 0) store(TXA + 32'h8, $urandom);
                repeat ($urandom_range(0, 2)) tick();
            end
            drain($sformatf("rand%0d", r), 1'b1);
        end
        chk("end_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
